// File: rtl/dz_pkg.sv
// Shared definitions for the incubator dot-matrix display slice.
//   DZ_ROWS/DZ_COLS : default matrix geometry
//   DZ_MAX_STAGE    : highest stage with a defined pattern
//   dz_stage_e      : hatch stage encoding (EGG0..EGG4, HATCH0..HATCH6)
//   dz_cmode_e      : column colour mode
//   EGG_TBL         : 8x8 pattern per stage, row r in bits [8r+7:8r]
package dz_pkg;

  localparam int DZ_ROWS      = 8;
  localparam int DZ_COLS      = 8;
  localparam int DZ_MAX_STAGE = 11;

  typedef enum logic [3:0] {
    EGG0   = 4'd0,
    EGG1   = 4'd1,
    EGG2   = 4'd2,
    EGG3   = 4'd3,
    EGG4   = 4'd4,
    HATCH0 = 4'd5,
    HATCH1 = 4'd6,
    HATCH2 = 4'd7,
    HATCH3 = 4'd8,
    HATCH4 = 4'd9,
    HATCH5 = 4'd10,
    HATCH6 = 4'd11
  } dz_stage_e;

  typedef enum logic [1:0] {
    CM_GREEN     = 2'd0,
    CM_YELLOW    = 2'd1,
    CM_RED_BLINK = 2'd2
  } dz_cmode_e;

  // Written row7..row0 left to right; entries above HATCH6 are blank.
  localparam logic [63:0] EGG_TBL [0:15] = '{
    64'h0000_183C_3C18_0000,  // EGG0
    64'h0000_387C_7C38_0000,  // EGG1
    64'h0000_3C7E_7E3C_0000,  // EGG2
    64'h003C_7E7E_7E7E_3C00,  // EGG3
    64'h3C7E_FFFF_FFFF_7E3C,  // EGG4
    64'h3C7E_FFFF_F7FF_7E3C,  // HATCH0: first crack
    64'h3C7E_FFF7_EBFF_7E3C,  // HATCH1
    64'h3C7E_FFE3_D5FF_7E3C,  // HATCH2
    64'h3C7E_FFDB_817E_3C00,  // HATCH3: shell opening
    64'h3C7E_FFFF_DB66_1800,  // HATCH4
    64'h2466_7E7E_DB7E_3C18,  // HATCH5: chick emerging
    64'h2424_3C7E_7EDB_7E3C,  // HATCH6: chick
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000
  };

endpackage

// File: rtl/dz_egg_rom.sv
// Combinational stage/row pattern lookup.
//   stage   : stage to look up
//   row_idx : matrix row
//   pat     : column pattern for that row (0 for undefined stages or rows >= 8)
module dz_egg_rom
  import dz_pkg::*;
#(
  parameter int COLS    = DZ_COLS,
  parameter int STAGE_W = 4,
  parameter int RW      = 3
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [RW-1:0]      row_idx,
  output logic [COLS-1:0]    pat
);

  logic [3:0]  sidx_s;
  logic [2:0]  ridx_s;
  logic [63:0] tbl_s;
  logic [7:0]  row8_s;

  // Table lookup guarded on the full-width stage and row so narrowed indices never alias.
  always_comb begin
    sidx_s = 4'(stage);
    ridx_s = 3'(row_idx);
    tbl_s  = 64'h0;
    row8_s = 8'h00;
    if ((int'(stage) <= int'(HATCH6)) && (int'(row_idx) < 8)) begin
      tbl_s  = EGG_TBL[sidx_s];
      row8_s = tbl_s[{ridx_s, 3'b000} +: 8];
    end else begin
      tbl_s  = 64'h0;
      row8_s = 8'h00;
    end
  end

  assign pat = COLS'(row8_s);

endmodule

// File: rtl/dz_scan_ctrl.sv
// Row-scanned red/green LED dot-matrix driver.
//   clk, rst    : scan clock, asynchronous active-high reset
//   en          : display enable (0 = dark, scan held at row 0)
//   stage       : hatch stage to show (latched at frame boundaries)
//   warn        : temperature fault (latched at frame boundaries)
//   blink_en    : blink red while warn is set (latched at frame boundaries)
//   row         : active-low one-cold row select
//   colr, colg  : active-high red/green column drive
//   frame_start : pulse in the cycle row 0 of a new frame first appears
//   stage_shown : stage currently latched for display
module dz_scan_ctrl
  import dz_pkg::*;
#(
  parameter int ROWS         = DZ_ROWS,
  parameter int COLS         = DZ_COLS,
  parameter int SCAN_DIV     = 1,
  parameter int BLANK_CYC    = 0,
  parameter int STAGE_W      = 4,
  parameter int MAX_STAGE    = DZ_MAX_STAGE,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [STAGE_W-1:0] stage,
  input  logic               warn,
  input  logic               blink_en,
  output logic [ROWS-1:0]    row,
  output logic [COLS-1:0]    colr,
  output logic [COLS-1:0]    colg,
  output logic               frame_start,
  output logic [STAGE_W-1:0] stage_shown
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pre_r, pre_nxt_s;
  logic [RW-1:0] row_idx_r, row_idx_nxt_s;
  logic [FW-1:0] frm_cnt_r, frm_cnt_nxt_s;
  logic          blink_ph_r, blink_ph_nxt_s;
  logic          warn_l_r, blink_l_r;
  logic          last_pre_s, boundary_s, latch_s;

  logic [COLS-1:0] rom_pat_s, pat_s, colr_nxt_s, colg_nxt_s;
  logic [ROWS-1:0] row_nxt_s;
  logic            fs_nxt_s, blank_s;
  dz_cmode_e       mode_s;

  dz_egg_rom #(
    .COLS    (COLS),
    .STAGE_W (STAGE_W),
    .RW      (RW)
  ) u_rom (
    .stage   (stage_shown),
    .row_idx (row_idx_r),
    .pat     (rom_pat_s)
  );

  // Prescaler, row counter and frame/blink counter next state.
  always_comb begin
    last_pre_s     = (pre_r == PW'(SCAN_DIV - 1));
    boundary_s     = last_pre_s && (row_idx_r == RW'(ROWS - 1));
    pre_nxt_s      = pre_r;
    row_idx_nxt_s  = row_idx_r;
    frm_cnt_nxt_s  = frm_cnt_r;
    blink_ph_nxt_s = blink_ph_r;
    if (!en) begin
      pre_nxt_s      = '0;
      row_idx_nxt_s  = '0;
      frm_cnt_nxt_s  = '0;
      blink_ph_nxt_s = 1'b0;
    end else begin
      if (last_pre_s) begin
        pre_nxt_s     = '0;
        row_idx_nxt_s = (row_idx_r == RW'(ROWS - 1)) ? '0 : row_idx_r + RW'(1);
      end else begin
        pre_nxt_s     = pre_r + PW'(1);
        row_idx_nxt_s = row_idx_r;
      end
      if (boundary_s) begin
        if (frm_cnt_r == FW'(BLINK_FRAMES - 1)) begin
          frm_cnt_nxt_s  = '0;
          blink_ph_nxt_s = ~blink_ph_r;
        end else begin
          frm_cnt_nxt_s  = frm_cnt_r + FW'(1);
          blink_ph_nxt_s = blink_ph_r;
        end
      end else begin
        frm_cnt_nxt_s  = frm_cnt_r;
        blink_ph_nxt_s = blink_ph_r;
      end
    end
  end

  // Inputs are tracked continuously while dark, otherwise only at frame boundaries.
  assign latch_s = !en || boundary_s;

  // Scan state and display latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r       <= '0;
      row_idx_r   <= '0;
      frm_cnt_r   <= '0;
      blink_ph_r  <= 1'b0;
      warn_l_r    <= 1'b0;
      blink_l_r   <= 1'b0;
      stage_shown <= '0;
    end else begin
      pre_r      <= pre_nxt_s;
      row_idx_r  <= row_idx_nxt_s;
      frm_cnt_r  <= frm_cnt_nxt_s;
      blink_ph_r <= blink_ph_nxt_s;
      if (latch_s) begin
        warn_l_r    <= warn;
        blink_l_r   <= blink_en;
        stage_shown <= stage;
      end else begin
        warn_l_r    <= warn_l_r;
        blink_l_r   <= blink_l_r;
        stage_shown <= stage_shown;
      end
    end
  end

  // Column pattern, colour mode and row select for the current slot.
  always_comb begin
    blank_s    = (BLANK_CYC > 0) && (int'(pre_r) < BLANK_CYC);
    pat_s      = rom_pat_s;
    mode_s     = CM_GREEN;
    colr_nxt_s = '0;
    colg_nxt_s = '0;
    row_nxt_s  = '1;
    fs_nxt_s   = 1'b0;
    if (blank_s || (int'(stage_shown) > MAX_STAGE)) begin
      pat_s = '0;
    end else begin
      pat_s = rom_pat_s;
    end
    if (!warn_l_r) begin
      mode_s = CM_GREEN;
    end else if (!blink_l_r) begin
      mode_s = CM_YELLOW;
    end else begin
      mode_s = CM_RED_BLINK;
    end
    if (en) begin
      row_nxt_s = ~(ROWS'(1'b1) << row_idx_r);
      fs_nxt_s  = (pre_r == '0) && (row_idx_r == '0);
      case (mode_s)
        CM_GREEN: begin
          colr_nxt_s = '0;
          colg_nxt_s = pat_s;
        end
        CM_YELLOW: begin
          colr_nxt_s = pat_s;
          colg_nxt_s = pat_s;
        end
        CM_RED_BLINK: begin
          colr_nxt_s = blink_ph_r ? '0 : pat_s;
          colg_nxt_s = '0;
        end
        default: begin
          colr_nxt_s = '0;
          colg_nxt_s = '0;
        end
      endcase
    end else begin
      row_nxt_s  = '1;
      fs_nxt_s   = 1'b0;
      colr_nxt_s = '0;
      colg_nxt_s = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= '1;
      colr        <= '0;
      colg        <= '0;
      frame_start <= 1'b0;
    end else begin
      row         <= row_nxt_s;
      colr        <= colr_nxt_s;
      colg        <= colg_nxt_s;
      frame_start <= fs_nxt_s;
    end
  end

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Self-checking bench for dz_scan_ctrl. Two instances share the inputs:
//   dut_a : SCAN_DIV=1, BLANK_CYC=0, BLINK_FRAMES=2
//   dut_b : SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=64
// Expected outputs are queued per instance as each cycle's stimulus is applied
// and compared after the clock edge that produces them.
module tb_dz_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, warn, blink_en;
  logic [3:0] stage;

  logic [7:0] row_a, colr_a, colg_a, row_b, colr_b, colg_b;
  logic       fs_a, fs_b;
  logic [3:0] ss_a, ss_b;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       fs;
    logic [3:0] ss;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int errors = 0;
  int checks = 0;

  // Per-instance model state
  int   sd_v[2] = '{1, 4};
  int   bl_v[2] = '{0, 1};
  int   bf_v[2] = '{2, 64};
  int   t_v[2];
  int   sh_stage[2];
  logic sh_warn[2];
  logic sh_blink[2];

  always #5 clk = ~clk;

  dz_scan_ctrl #(.SCAN_DIV(1), .BLANK_CYC(0), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .stage(stage), .warn(warn), .blink_en(blink_en),
    .row(row_a), .colr(colr_a), .colg(colg_a), .frame_start(fs_a), .stage_shown(ss_a)
  );

  dz_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(64)) dut_b (
    .clk(clk), .rst(rst), .en(en), .stage(stage), .warn(warn), .blink_en(blink_en),
    .row(row_b), .colr(colr_b), .colg(colg_b), .frame_start(fs_b), .stage_shown(ss_b)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference egg patterns for the stages the bench displays.
  function automatic logic [7:0] egg_row(input int s, input int r);
    case (s)
      0: egg_row = (r == 2 || r == 5) ? 8'h18 : (r == 3 || r == 4) ? 8'h3C : 8'h00;
      1: egg_row = (r == 2 || r == 5) ? 8'h38 : (r == 3 || r == 4) ? 8'h7C : 8'h00;
      2: egg_row = (r == 2 || r == 5) ? 8'h3C : (r == 3 || r == 4) ? 8'h7E : 8'h00;
      3: egg_row = (r == 1 || r == 6) ? 8'h3C : (r >= 2 && r <= 5) ? 8'h7E : 8'h00;
      4: egg_row = (r == 0 || r == 7) ? 8'h3C : (r == 1 || r == 6) ? 8'h7E : 8'hFF;
      default: egg_row = 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t_v[i] = 0; sh_stage[i] = 0; sh_warn[i] = 1'b0; sh_blink[i] = 1'b0;
    end
  endtask

  // Expected output for the coming clock edge, given the inputs now applied.
  task automatic model_push(input int i);
    exp_t e;
    int p, ri, f, per;
    logic [7:0] pat;
    logic ph;
    per = sd_v[i] * 8;
    if (!en) begin
      e.row = 8'hFF; e.colr = 8'h00; e.colg = 8'h00; e.fs = 1'b0;
      sh_stage[i] = int'(stage); sh_warn[i] = warn; sh_blink[i] = blink_en;
      t_v[i] = 0;
    end else begin
      p   = t_v[i] % sd_v[i];
      ri  = (t_v[i] / sd_v[i]) % 8;
      f   = t_v[i] / per;
      ph  = ((f / bf_v[i]) % 2) == 1;
      pat = (sh_stage[i] <= 11) ? egg_row(sh_stage[i], ri) : 8'h00;
      if (p < bl_v[i]) pat = 8'h00;
      e.row = ~(8'h01 << ri);
      if (!sh_warn[i]) begin
        e.colr = 8'h00; e.colg = pat;
      end else if (!sh_blink[i]) begin
        e.colr = pat; e.colg = pat;
      end else begin
        e.colr = ph ? 8'h00 : pat; e.colg = 8'h00;
      end
      e.fs = (t_v[i] % per) == 0;
      if ((t_v[i] % per) == per - 1) begin
        sh_stage[i] = int'(stage); sh_warn[i] = warn; sh_blink[i] = blink_en;
      end
      t_v[i]++;
    end
    e.ss = 4'(sh_stage[i]);
    if (i == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic compare(input string nm, input exp_t e, input logic [7:0] r,
                         input logic [7:0] cr, input logic [7:0] cg, input logic f,
                         input logic [3:0] s);
    check_val({nm, "_row"},  32'(r),  32'(e.row));
    check_val({nm, "_colr"}, 32'(cr), 32'(e.colr));
    check_val({nm, "_colg"}, 32'(cg), 32'(e.colg));
    check_val({nm, "_fs"},   32'(f),  32'(e.fs));
    check_val({nm, "_ss"},   32'(s),  32'(e.ss));
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      model_push(0);
      model_push(1);
      @(posedge clk);
      #1;
      if (q_a.size() == 0) check_val("sb_a_empty", 32'd0, 32'd1);
      else begin e = q_a.pop_front(); compare("a", e, row_a, colr_a, colg_a, fs_a, ss_a); end
      if (q_b.size() == 0) check_val("sb_b_empty", 32'd0, 32'd1);
      else begin e = q_b.pop_front(); compare("b", e, row_b, colr_b, colg_b, fs_b, ss_b); end
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_row_a"},  32'(row_a),  32'hFF);
    check_val({tag, "_cols_a"}, 32'({colr_a, colg_a}), 32'h0);
    check_val({tag, "_fs_a"},   32'(fs_a),   32'h0);
    check_val({tag, "_ss_a"},   32'(ss_a),   32'h0);
    check_val({tag, "_row_b"},  32'(row_b),  32'hFF);
    check_val({tag, "_cols_b"}, 32'({colr_b, colg_b}), 32'h0);
    check_val({tag, "_ss_b"},   32'(ss_b),   32'h0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; warn = 1'b0; blink_en = 1'b0; stage = 4'd0;
    @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    model_reset();

    // Basic scan, stage 0 green
    en = 1'b1;
    step(24);
    // Stage change mid-frame (dut_a at row 3)
    step(3);
    stage = 4'd4;
    step(21);
    // Yellow warning, then red blink
    stage = 4'd2; warn = 1'b1;
    step(16);
    blink_en = 1'b1;
    step(80);
    // Back to green stage 4 (exercises dut_b blanking)
    warn = 1'b0; blink_en = 1'b0; stage = 4'd4;
    step(64);
    // Out-of-range stage, then en dropped mid-frame and restored
    stage = 4'd13;
    step(19);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(20);
    // Asynchronous reset mid-cycle
    step(3);
    #3;
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    stage = 4'd1;
    rst = 1'b0;
    model_reset();
    step(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
